// File: rtl/lisa_pkg.sv
// Shared LISA core definitions: access-size encodings, LSU state type and datapath widths.
package lisa_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StRmwWr,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/lisa_lsu_align.sv
// Combinational load extraction/extension and sub-word store merge for the LSU.
module lisa_lsu_align
  import lisa_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged_data
);

  // The memory returns the addressed byte in bits [7:0], so no lane shifting is needed.
  always_comb begin
    load_data   = rdata;
    merged_data = wdata;
    unique case (size)
      SIZE_B: begin
        load_data   = {{24{sign_ext & rdata[7]}}, rdata[7:0]};
        merged_data = {rdata[31:8], wdata[7:0]};
      end
      SIZE_H: begin
        load_data   = {{16{sign_ext & rdata[15]}}, rdata[15:0]};
        merged_data = {rdata[31:16], wdata[15:0]};
      end
      default: begin
        load_data   = rdata;
        merged_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lisa_lsu.sv
// LISA load/store unit: one request at a time, sub-word stores via read-modify-write,
// range/size fault detection against a word-write data memory.
module lisa_lsu
  import lisa_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [ADDR_W:0]   nbytes;
  logic [ADDR_W:0]   end_addr;
  logic              req_fault;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_data;

  // 17-bit end address so a request near 0xFFFF cannot wrap into range.
  always_comb begin
    unique case (req_size)
      SIZE_H:  nbytes = 17'd2;
      SIZE_W:  nbytes = 17'd4;
      default: nbytes = 17'd1;
    endcase
    end_addr  = {1'b0, req_addr} + nbytes;
    req_fault = (req_size == 2'b11) || ({15'd0, end_addr} > MEM_BYTES);
  end

  lisa_lsu_align u_align (
    .size        (size_q),
    .sign_ext    (signed_q),
    .rdata       (mem_read_data),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged_data (merged_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    fault_d     = fault_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_size;
          signed_d   = req_signed;
          wdata_d    = req_wdata;
          rdata_d    = '0;
          fault_d    = req_fault;
          mem_addr_d = req_addr;
          if (req_fault) begin
            state_d = StResp;
          end else begin
            state_d = StAccess;
            // Word stores write straight away; the strobe is high throughout ACCESS.
            if (req_we && req_size == SIZE_W) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = req_wdata;
            end
          end
        end
      end
      StAccess: begin
        if (!we_q) begin
          rdata_d = load_data;
          state_d = StResp;
        end else if (size_q == SIZE_W) begin
          state_d = StResp;
        end else begin
          mem_we_d    = 1'b1;
          mem_wdata_d = merged_data;
          state_d     = StRmwWr;
        end
      end
      StRmwWr: state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      size_q      <= SIZE_B;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      fault_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    req_ready      = (state_q == StIdle);
    resp_valid     = (state_q == StResp);
    resp_rdata     = resp_valid ? rdata_q : '0;
    resp_fault     = resp_valid & fault_q;
    mem_addr       = mem_addr_q;
    mem_write_en   = mem_we_q;
    mem_write_data = mem_wdata_q;
  end

endmodule

// File: tb/tb_lisa_lsu.sv
// Directed scoreboard bench for lisa_lsu with a behavioural 1 KiB word-write data memory.
module tb_lisa_lsu;
  import lisa_pkg::*;

  localparam int unsigned MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = SIZE_B;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [15:0] mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  lisa_lsu #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, whole-word write, out-of-range bytes dropped.
  logic [7:0] mem [MEM_BYTES];

  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (int'(mem_addr) + i < int'(MEM_BYTES)) mem_read_data[8*i +: 8] = mem[int'(mem_addr) + i];
    end
  end

  always @(posedge clk) begin
    if (mem_write_en) begin
      for (int i = 0; i < 4; i++) begin
        if (int'(mem_addr) + i < int'(MEM_BYTES))
          mem[int'(mem_addr) + i] <= mem_write_data[8*i +: 8];
      end
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   resp_cnt = 0;
  int   wr_cnt = 0;
  int   wr_off = 0;
  int   last_acc = 0;
  exp_t e;
  int   a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid && req_ready) begin
      acc_q.push_back(cyc);
      last_acc = cyc;
      acc_cnt++;
    end
  end

  // Response and write monitor; latencies count cycles from the accept edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write_en) begin
        wr_cnt++;
        wr_off = cyc - last_acc;
      end
      if (resp_valid) begin
        resp_cnt++;
        if (sb.size() == 0 || acc_q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          a = acc_q.pop_front();
          check({e.tag, "_rdata"}, resp_rdata, e.rdata);
          check({e.tag, "_fault"}, 32'(resp_fault), 32'(e.fault));
          check({e.tag, "_latency"}, 32'(cyc - a), 32'(e.lat));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [15:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_fault, input int lat,
                        input int exp_wr, input string tag);
    int w0, a0, r0, n;
    step();
    w0 = wr_cnt;
    a0 = acc_cnt;
    r0 = resp_cnt;
    sb.push_back('{tag, exp_rdata, exp_fault, lat});
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    n = 0;
    while (acc_cnt == a0 && n < 20) begin
      step();
      n++;
    end
    req_valid = 1'b0;
    check({tag, "_accepted"}, 32'(acc_cnt - a0), 32'd1);
    n = 0;
    while (resp_cnt == r0 && n < 10) begin
      step();
      n++;
    end
    check({tag, "_responded"}, 32'(resp_cnt - r0), 32'd1);
    if (resp_cnt == r0) begin
      sb.delete();
      acc_q.delete();
    end
    check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
    if (exp_wr == 1) check({tag, "_write_cycle"}, 32'(wr_off), (size == SIZE_W) ? 32'd1 : 32'd2);
  endtask

  logic [1:0]  b_size [3] = '{SIZE_W, 2'b11, SIZE_B};
  logic [15:0] b_addr [3] = '{16'h0010, 16'h0000, 16'h0012};
  logic [31:0] b_exp  [3] = '{32'hDEAD5AEF, 32'h0, 32'h000000AD};
  logic        b_flt  [3] = '{1'b0, 1'b1, 1'b0};
  int          b_lat  [3] = '{2, 1, 2};

  initial begin
    int a0, r0, w0, n;
    for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_we", 32'(mem_write_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    step();
    rst = 1'b0;

    do_req(1'b1, SIZE_W, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, "word_store");
    check("word_store_mem", {mem[16'h13], mem[16'h12], mem[16'h11], mem[16'h10]}, 32'hDEADBEEF);
    do_req(1'b0, SIZE_W, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, "word_load");
    do_req(1'b1, SIZE_B, 1'b0, 16'h0011, 32'h1234565A, 32'h0, 1'b0, 3, 1, "byte_store");
    do_req(1'b0, SIZE_W, 1'b0, 16'h0010, 32'h0, 32'hDEAD5AEF, 1'b0, 2, 0, "merge_load");
    do_req(1'b0, SIZE_B, 1'b1, 16'h0013, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0, "lb_signed");
    do_req(1'b0, SIZE_B, 1'b0, 16'h0013, 32'h0, 32'h000000DE, 1'b0, 2, 0, "lb_unsigned");
    do_req(1'b0, SIZE_H, 1'b1, 16'h0012, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 0, "lh_signed");
    do_req(1'b0, SIZE_W, 1'b0, 16'h03FE, 32'h0, 32'h0, 1'b1, 1, 0, "fault_range");
    do_req(1'b1, SIZE_H, 1'b0, 16'hFFFF, 32'hFFFF, 32'h0, 1'b1, 1, 0, "fault_wrap");
    do_req(1'b1, 2'b11, 1'b0, 16'h0010, 32'h0, 32'h0, 1'b1, 1, 0, "fault_size");
    do_req(1'b0, SIZE_W, 1'b0, 16'h03FC, 32'h0, 32'h0, 1'b0, 2, 0, "top_word");

    // Back-to-back: req_valid stays high across three different requests.
    step();
    a0 = acc_cnt;
    r0 = resp_cnt;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_we     = 1'b0;
      req_signed = 1'b0;
      req_size   = b_size[i];
      req_addr   = b_addr[i];
      sb.push_back('{$sformatf("b2b%0d", i), b_exp[i], b_flt[i], b_lat[i]});
      n = 0;
      while (acc_cnt < a0 + i + 1 && n < 20) begin
        step();
        n++;
      end
      check("b2b_busy_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    n = 0;
    while (resp_cnt < r0 + 3 && n < 20) begin
      step();
      n++;
    end
    repeat (3) step();
    check("b2b_accepts", 32'(acc_cnt - a0), 32'd3);
    check("b2b_resps", 32'(resp_cnt - r0), 32'd3);
    sb.delete();
    acc_q.delete();

    // Reset during RMW_WR of a byte store.
    do_req(1'b1, SIZE_W, 1'b0, 16'h0020, 32'h11223344, 32'h0, 1'b0, 2, 1, "pre_rst_store");
    step();
    w0 = wr_cnt;
    a0 = acc_cnt;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = SIZE_B;
    req_addr  = 16'h0020;
    req_wdata = 32'h99;
    n = 0;
    while (acc_cnt == a0 && n < 20) begin
      step();
      n++;
    end
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("rmw_we_before_rst", 32'(mem_write_en), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_we_drop", 32'(mem_write_en), 32'd0);
    check("rst_resp_drop", 32'(resp_valid), 32'd0);
    @(posedge clk);
    step();
    rst = 1'b0;
    acc_q.delete();
    repeat (4) step();
    check("rst_mem_intact", {mem[16'h23], mem[16'h22], mem[16'h21], mem[16'h20]}, 32'h11223344);
    check("rst_no_write", 32'(wr_cnt - w0), 32'd0);
    check("rst_ready_after", 32'(req_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/lisa_lsu.md
# lisa_lsu

Load/store unit that initiates all data-memory traffic for the LISA core: it accepts one load or store request at a time from the execute stage and drives the data memory's combinational-read, 32-bit-write port (`lisa_data_mem`). It adds byte/half/word access sizes, sign or zero extension on loads, read-modify-write for sub-word stores (the memory only writes whole 4-byte little-endian words), and out-of-range fault detection.

## Interface
- `MEM_BYTES`, 1024: size of the attached data memory in bytes. Must match the memory instance.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: unit idle, request accepted on `req_valid && req_ready` at a rising edge.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_size`  in  2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  16: byte address.
- `req_wdata`  in  32: store data, low bytes used for sub-word stores.
- `resp_valid`  out  1: one-cycle completion pulse; there is no backpressure.
- `resp_rdata`  out  32: extended load data. 0 for stores and faults.
- `resp_fault`  out  1: valid with `resp_valid`; request was illegal or out of range.
- `mem_addr`  out  16: registered address to the memory.
- `mem_write_en`  out  1: registered write strobe.
- `mem_write_data`  out  32: registered write word.
- `mem_read_data`  in  32: combinational read of bytes `mem_addr`..`mem_addr+3`, with `mem_addr` in the low byte.

## Operation
- States: IDLE, ACCESS, RMW_WR, RESP.
- IDLE:
  - `req_ready`=1.
  - On accept, latch all request fields and load `mem_addr`.
  - Compute `nbytes` (1, 2 or 4) and a 17-bit `end = addr + nbytes`, so there is no 16-bit wrap.
  - Fault if `req_size`==11 or `end > MEM_BYTES`. A fault goes to RESP with `resp_fault`=1 and performs no memory access.
  - Otherwise go to ACCESS.
- ACCESS:
  - Load: capture `mem_read_data`. Byte = `[7:0]`, half = `[15:0]`, extended per `req_signed`; word passes through unchanged. Go to RESP.
  - Word store: `mem_write_en`=1 and `mem_write_data`=`req_wdata` during this cycle. Go to RESP.
  - Sub-word store: capture the old word. Build the merged word: `{old[31:8], wdata[7:0]}` for a byte, `{old[31:16], wdata[15:0]}` for a half. Go to RMW_WR.
- RMW_WR: `mem_write_en`=1 with the merged word for exactly one cycle, then go to RESP.
- RESP: `resp_valid`=1 for one cycle, then go to IDLE.
- `req_ready` is 0 in every state except IDLE. `req_valid` held high while busy is not accepted again until the unit returns to IDLE.
- Reset values: state IDLE, `req_ready`=1, all other outputs 0.
- `rst` asserted in any state clears state and outputs immediately. No write occurs at the next edge and the in-flight request is dropped without a response.
- A sub-word RMW near the top of memory may write back old bytes beyond `MEM_BYTES`. The memory discards those writes, and this is legal.

## Timing
- Cycle 0 is the accept edge.
- Fault: `resp_valid` in cycle 1.
- Load and word store: ACCESS in cycle 1, `resp_valid` in cycle 2. The word-store write lands at the end of cycle 1.
- Sub-word store: read in cycle 1, `mem_write_en` in cycle 2, `resp_valid` in cycle 3.
- Exactly one `mem_write_en` cycle per non-faulting store; zero for loads and faults.
- Back-to-back throughput: one request per 3 cycles (load, word store), per 4 cycles (sub-word store), per 2 cycles (fault).

## Structure
- Shared package `lisa_pkg` holds:
  - the `req_size` encodings (`SIZE_B`, `SIZE_H`, `SIZE_W`);
  - the state enum;
  - any width constants shared with the core.
- One combinational sub-module, `lisa_lsu_align`, performs load extraction/extension and store merging. The FSM and registers stay in `lisa_lsu`.

## Test plan
All scenarios use `MEM_BYTES`=1024 with a `lisa_data_mem` instance attached.
- Word round trip: word store of 0xDEADBEEF at 0x010, then word load at 0x010 → memory bytes 0x10..0x13 = EF BE AD DE; load `resp_rdata`=0xDEADBEEF with `resp_valid` at accept+2.
- Byte store merge: after the word round trip, byte store of 0x5A at 0x011 → one `mem_write_en` cycle at accept+2 and `resp_valid` at accept+3; a following word load at 0x010 returns 0xDEAD5AEF.
- Extension, from the memory state after the byte store:
  - signed byte load at 0x013 → 0xFFFFFFDE;
  - unsigned byte load at 0x013 → 0x000000DE;
  - signed half load at 0x012 → 0xFFFFDEAD.
- Faults: each case gives `resp_fault`=1, `resp_rdata`=0 and `resp_valid` at accept+1, with no `mem_write_en`.
  - word load at 0x3FE;
  - half store at 0xFFFF;
  - `req_size`=11.
- Back-to-back: `req_valid` held high for three different requests → `req_ready` low while busy; each request is accepted and responded to exactly once, in order.
- Reset mid-RMW: assert `rst` during RMW_WR of a byte store → `mem_write_en` drops immediately, memory is unchanged, no `resp_valid`, and `req_ready`=1 after release.
